// File: rtl/riscv_pkg.sv
// Shared RV64 core definitions: widths, fetch FSM states and opcode constants
// used by fetch, decode and the immediate extender.
package riscv_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with a one-entry skid buffer that catches a fetched
// word arriving while decode is stalled.
module if_id_reg #(
  parameter int XLEN = 64,
  parameter int ILEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            stall,
  input  logic            load,
  input  logic [ILEN-1:0] load_instr,
  input  logic [XLEN-1:0] load_pc,
  output logic            consumed,
  output logic            skid_full,
  output logic            valid,
  output logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] pc
);
  import riscv_pkg::*;

  logic            skid_valid;
  logic [ILEN-1:0] skid_instr;
  logic [XLEN-1:0] skid_pc;
  logic            accept;

  assign accept    = !stall || !valid;
  // A word is consumed only when it goes straight into IF/ID, not into the skid.
  assign consumed  = load && accept && !skid_valid && !flush;
  assign skid_full = skid_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid      <= 1'b0;
      instr      <= ILEN'(NOP_INSTR);
      pc         <= '0;
      skid_valid <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else if (flush) begin
      valid      <= 1'b0;
      skid_valid <= 1'b0;
    end else if (accept) begin
      if (skid_valid) begin
        valid      <= 1'b1;
        instr      <= skid_instr;
        pc         <= skid_pc;
        skid_valid <= load;
        if (load) begin
          skid_instr <= load_instr;
          skid_pc    <= load_pc;
        end
      end else if (load) begin
        valid <= 1'b1;
        instr <= load_instr;
        pc    <= load_pc;
      end else begin
        valid <= 1'b0;
      end
    end else if (load) begin
      skid_valid <= 1'b1;
      skid_instr <= load_instr;
      skid_pc    <= load_pc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register and request FSM with at most one outstanding
// memory request; IF/ID storage lives in if_id_reg.
module fetch_stage #(
  parameter int               XLEN     = riscv_pkg::XLEN,
  parameter int               ILEN     = riscv_pkg::ILEN,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_id_valid,
  output logic [ILEN-1:0] if_id_instr,
  output logic [XLEN-1:0] if_id_pc
);
  import riscv_pkg::*;

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;
  logic            resp;
  logic            consumed;
  logic            skid_full;

  assign imem_addr = pc & ~(XLEN'(3));
  assign resp      = (state == S_WAIT) && imem_rvalid && !redirect;

  // Redirect suppresses any request so the first new fetch targets redirect_pc.
  always_comb begin
    imem_req = 1'b0;
    if (rst_n && !redirect) begin
      case (state)
        S_REQ:   imem_req = !skid_full;
        S_WAIT:  imem_req = imem_rvalid && consumed;
        default: imem_req = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_REQ;
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
    end else begin
      if (imem_req) begin
        req_pc <= imem_addr;
        pc     <= imem_addr + XLEN'(4);
      end
      if (redirect) begin
        pc <= redirect_pc & ~(XLEN'(3));
      end
      case (state)
        S_REQ: begin
          if (imem_req) state <= S_WAIT;
        end
        S_WAIT: begin
          if (redirect) state <= imem_rvalid ? S_REQ : S_DROP;
          else if (imem_rvalid) state <= imem_req ? S_WAIT : S_REQ;
        end
        S_DROP: begin
          if (imem_rvalid) state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end
  end

  if_id_reg #(
    .XLEN(XLEN),
    .ILEN(ILEN)
  ) u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect),
    .stall      (stall),
    .load       (resp),
    .load_instr (imem_rdata),
    .load_pc    (req_pc),
    .consumed   (consumed),
    .skid_full  (skid_full),
    .valid      (if_id_valid),
    .instr      (if_id_instr),
    .pc         (if_id_pc)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a behavioural instruction memory returning
// mem[a]=a with programmable latency, plus a second instance for PC wrap.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [63:0] if_id_pc;

  logic        w_req;
  logic [63:0] w_addr;
  logic        w_rvalid;
  logic [31:0] w_rdata;
  logic        w_stall;
  logic        w_redirect;
  logic [63:0] w_redirect_pc;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [63:0] w_pc;

  int          checks = 0;
  int          errors = 0;

  bit          mem_busy;
  int          mem_cnt;
  int          mem_lat;
  logic [63:0] mem_addr;

  always #5 clk = ~clk;

  fetch_stage #(
    .XLEN(64), .ILEN(32), .RESET_PC(64'h0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_id_valid (if_id_valid),
    .if_id_instr (if_id_instr),
    .if_id_pc    (if_id_pc)
  );

  fetch_stage #(
    .XLEN(64), .ILEN(32), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)
  ) dut_wrap (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (w_req),
    .imem_addr   (w_addr),
    .imem_rvalid (w_rvalid),
    .imem_rdata  (w_rdata),
    .stall       (w_stall),
    .redirect    (w_redirect),
    .redirect_pc (w_redirect_pc),
    .if_id_valid (w_valid),
    .if_id_instr (w_instr),
    .if_id_pc    (w_pc)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_ifid(input string tag, input logic v, input logic [63:0] p, input logic [31:0] i);
    check({tag, "_valid"}, 64'(if_id_valid), 64'(v));
    check({tag, "_pc"}, if_id_pc, p);
    check({tag, "_instr"}, 64'(if_id_instr), 64'(i));
  endtask

  // One clock: sample the request mid-cycle, then advance the memory model.
  task automatic tick();
    logic        req_s;
    logic [63:0] addr_s;
    @(negedge clk);
    req_s  = imem_req;
    addr_s = imem_addr;
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    if (req_s) begin
      mem_busy = 1'b1;
      mem_cnt  = mem_lat;
      mem_addr = addr_s;
    end
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_addr[31:0];
        mem_busy    = 1'b0;
      end
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    w_rvalid = 1'b0; w_rdata = '0; w_stall = 1'b0; w_redirect = 1'b0; w_redirect_pc = '0;
    mem_busy = 1'b0; mem_cnt = 0; mem_lat = 1; mem_addr = '0;
    repeat (2) @(posedge clk);
    #1;

    check_ifid("rst", 1'b0, 64'h0, 32'h00000013);
    check("rst_req", 64'(imem_req), 64'd0);
    check("wrap_rst_addr", w_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_rst_instr", 64'(w_instr), 64'h13);
    check("wrap_rst_pc", w_pc, 64'h0);

    // Back-to-back fetch with 1-cycle memory
    rst_n = 1'b1;
    #1;
    check("first_req", 64'(imem_req), 64'd1);
    check("first_addr", imem_addr, 64'h0);
    check("wrap_first_req", 64'(w_req), 64'd1);
    tick();
    check("second_addr", imem_addr, 64'h4);
    check("second_req", 64'(imem_req), 64'd1);
    check("wrap_second_addr", w_addr, 64'h0);
    check("wrap_valid", 64'(w_valid), 64'd0);
    tick();
    check_ifid("seq0", 1'b1, 64'h0, 32'h0);
    tick();
    check_ifid("seq4", 1'b1, 64'h4, 32'h4);

    // Stall while the 0x8 word arrives: it goes to the skid buffer
    stall = 1'b1;
    #1;
    check("stall_req", 64'(imem_req), 64'd0);
    tick();
    check_ifid("stall_hold1", 1'b1, 64'h4, 32'h4);
    check("skid_full_req", 64'(imem_req), 64'd0);
    tick();
    check_ifid("stall_hold2", 1'b1, 64'h4, 32'h4);
    tick();
    check_ifid("stall_hold3", 1'b1, 64'h4, 32'h4);
    stall = 1'b0;
    #1;
    check("release_req", 64'(imem_req), 64'd0);
    tick();
    check_ifid("skid_out8", 1'b1, 64'h8, 32'h8);
    check("refetch_req", 64'(imem_req), 64'd1);
    check("refetch_addr", imem_addr, 64'hC);
    tick();
    check_ifid("bubble", 1'b0, 64'h8, 32'h8);
    tick();
    check_ifid("seqC", 1'b1, 64'hC, 32'hC);

    // Redirect with an outstanding request on 3-cycle memory
    mem_lat = 3;
    tick();
    check_ifid("seq10", 1'b1, 64'h10, 32'h10);
    redirect = 1'b1; redirect_pc = 64'h103;
    #1;
    check("redir_req", 64'(imem_req), 64'd0);
    tick();
    redirect = 1'b0;
    #1;
    check("redir_flush_valid", 64'(if_id_valid), 64'd0);
    check("drop_req0", 64'(imem_req), 64'd0);
    tick();
    check("stale_rvalid", 64'(imem_rvalid), 64'd1);
    check("drop_req1", 64'(imem_req), 64'd0);
    tick();
    check("stale_dropped", 64'(if_id_valid), 64'd0);
    check("redir_req_new", 64'(imem_req), 64'd1);
    check("redir_addr", imem_addr, 64'h100);
    tick();
    tick();
    tick();
    check("wait100_valid", 64'(if_id_valid), 64'd0);
    tick();
    check_ifid("seq100", 1'b1, 64'h100, 32'h100);

    // Redirect, rvalid and stall together
    tick();
    tick();
    stall = 1'b1; redirect = 1'b1; redirect_pc = 64'h200;
    #1;
    check("triple_req", 64'(imem_req), 64'd0);
    tick();
    redirect = 1'b0; stall = 1'b0; mem_lat = 1;
    #1;
    check("triple_flush_valid", 64'(if_id_valid), 64'd0);
    check("triple_req_new", 64'(imem_req), 64'd1);
    check("triple_addr", imem_addr, 64'h200);
    tick();
    tick();
    check_ifid("seq200", 1'b1, 64'h200, 32'h200);

    // Redirect while the skid buffer holds a word
    stall = 1'b1;
    tick();
    check_ifid("skid_hold200", 1'b1, 64'h200, 32'h200);
    redirect = 1'b1; redirect_pc = 64'h300;
    tick();
    redirect = 1'b0; stall = 1'b0;
    #1;
    check("skidflush_valid", 64'(if_id_valid), 64'd0);
    check("skidflush_addr", imem_addr, 64'h300);
    check("skidflush_req", 64'(imem_req), 64'd1);
    tick();
    check("skid_cleared", 64'(if_id_valid), 64'd0);
    tick();
    check_ifid("seq300", 1'b1, 64'h300, 32'h300);

    // Asynchronous reset while a 3-cycle request is outstanding
    mem_lat = 3;
    tick();
    check_ifid("seq304", 1'b1, 64'h304, 32'h304);
    rst_n = 1'b0;
    #1;
    check_ifid("async_rst", 1'b0, 64'h0, 32'h00000013);
    check("async_rst_req", 64'(imem_req), 64'd0);
    tick();
    tick();
    check("late_rvalid", 64'(imem_rvalid), 64'd1);
    mem_lat = 1;
    rst_n = 1'b1;
    #1;
    check("restart_req", 64'(imem_req), 64'd1);
    check("restart_addr", imem_addr, 64'h0);
    tick();
    check("late_ignored", 64'(if_id_valid), 64'd0);
    tick();
    check_ifid("restart0", 1'b1, 64'h0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
